// File: rtl/axis_header_extractor.sv
// rtl/axis_header_extractor.sv - strips a 1..DATA_BYTE_WD byte header and realigns the payload (optional HDR_SHORT_CHECK_EN)
module axis_header_extractor #(
    parameter  int DATA_WD      = 32,
    parameter  int DATA_BYTE_WD = DATA_WD / 8,
    localparam int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_len_tvalid,
    output logic                    s_len_tready,
    input  logic [LEN_WD-1:0]       s_len_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WD-1:0]      s_axis_tdata,
    input  logic [DATA_BYTE_WD-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    m00_axis_tvalid,
    input  logic                    m00_axis_tready,
    output logic [DATA_WD-1:0]      m00_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m00_axis_tkeep,
    output logic                    m01_axis_tvalid,
    input  logic                    m01_axis_tready,
    output logic [DATA_WD-1:0]      m01_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m01_axis_tkeep,
    output logic                    m01_axis_tlast
`ifdef HDR_SHORT_CHECK_EN
    ,
    output logic                    err_short_pkt
`endif
);

    typedef enum logic [1:0] {IDLE, FIRST, BODY, TAIL} state_t;

    localparam logic [LEN_WD-1:0] FULL_LEN = LEN_WD'(DATA_BYTE_WD);

    state_t               state;
    logic [LEN_WD-1:0]    hlen;
    logic [DATA_WD-1:0]   resid_q;
    logic [LEN_WD-1:0]    resid_cnt;

    // Keep mask with the top n byte lanes set.
    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input logic [LEN_WD-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[DATA_BYTE_WD-1-i] = (i < int'(n));
        end
        return m;
    endfunction

    // Expand a byte keep into a bit mask so unused output bytes read as zero.
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

    function automatic logic [LEN_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] keep);
        logic [LEN_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + LEN_WD'(keep[i]);
        end
        return c;
    endfunction

    logic [LEN_WD-1:0]       len_norm;
    logic [LEN_WD-1:0]       k;
    logic [LEN_WD-1:0]       resid_w;
    logic                    k_gt_h;
    logic [LEN_WD-1:0]       k_minus_h;
    logic [LEN_WD+2:0]       hsh;
    logic [LEN_WD+2:0]       rsh;
    logic [DATA_BYTE_WD-1:0] hdr_keep;
    logic [DATA_BYTE_WD-1:0] short_keep;
    logic [DATA_BYTE_WD-1:0] body_last_keep;
    logic [DATA_BYTE_WD-1:0] tail_keep;
    logic [DATA_WD-1:0]      body_data;
    logic                    hdr_free;
    logic                    pay_free;
    logic                    in_fire;

    // Byte arithmetic for the current beat against the latched header length.
    always_comb begin
        len_norm       = (s_len_tdata == '0 || s_len_tdata > FULL_LEN) ? FULL_LEN : s_len_tdata;
        k              = popcnt(s_axis_tkeep);
        resid_w        = FULL_LEN - hlen;
        k_gt_h         = (k > hlen);
        k_minus_h      = k_gt_h ? (k - hlen) : '0;
        hsh            = {hlen, 3'b000};
        rsh            = {resid_w, 3'b000};
        hdr_keep       = keep_top(k_gt_h ? hlen : k);
        short_keep     = keep_top(k_minus_h);
        body_last_keep = keep_top(resid_w + k);
        tail_keep      = keep_top(resid_cnt);
        body_data      = (resid_q << hsh) | (s_axis_tdata >> rsh);
    end

    // Input acceptance only depends on state and output register occupancy.
    always_comb begin
        hdr_free      = !m00_axis_tvalid || m00_axis_tready;
        pay_free      = !m01_axis_tvalid || m01_axis_tready;
        s_len_tready  = (state == IDLE);
        s_axis_tready = ((state == FIRST) || (state == BODY)) && pay_free &&
                        ((state != FIRST) || hdr_free);
        in_fire       = s_axis_tvalid && s_axis_tready;
    end

    // Packet FSM with registered header and payload output channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hlen            <= FULL_LEN;
            resid_q         <= '0;
            resid_cnt       <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tkeep  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tkeep  <= '0;
            m01_axis_tlast  <= 1'b0;
`ifdef HDR_SHORT_CHECK_EN
            err_short_pkt   <= 1'b0;
`endif
        end else begin
`ifdef HDR_SHORT_CHECK_EN
            err_short_pkt <= 1'b0;
`endif
            if (m00_axis_tvalid && m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end
            if (m01_axis_tvalid && m01_axis_tready) begin
                m01_axis_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (s_len_tvalid) begin
                        hlen  <= len_norm;
                        state <= FIRST;
                    end
                end
                FIRST: begin
                    if (in_fire) begin
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tdata  <= s_axis_tdata & byte_mask(hdr_keep);
                        m00_axis_tkeep  <= hdr_keep;
                        resid_q         <= s_axis_tdata;
                        resid_cnt       <= k_minus_h;
                        if (s_axis_tlast) begin
                            if (k_gt_h) begin
                                m01_axis_tvalid <= 1'b1;
                                m01_axis_tdata  <= (s_axis_tdata << hsh) & byte_mask(short_keep);
                                m01_axis_tkeep  <= short_keep;
                                m01_axis_tlast  <= 1'b1;
                            end
`ifdef HDR_SHORT_CHECK_EN
                            err_short_pkt <= (k < hlen);
`endif
                            state <= IDLE;
                        end else begin
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (in_fire) begin
                        m01_axis_tvalid <= 1'b1;
                        resid_q         <= s_axis_tdata;
                        resid_cnt       <= k_minus_h;
                        if (s_axis_tlast && !k_gt_h) begin
                            m01_axis_tdata <= body_data & byte_mask(body_last_keep);
                            m01_axis_tkeep <= body_last_keep;
                            m01_axis_tlast <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            m01_axis_tdata <= body_data;
                            m01_axis_tkeep <= '1;
                            m01_axis_tlast <= 1'b0;
                            if (s_axis_tlast) begin
                                state <= TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (pay_free) begin
                        m01_axis_tvalid <= 1'b1;
                        m01_axis_tdata  <= (resid_q << hsh) & byte_mask(tail_keep);
                        m01_axis_tkeep  <= tail_keep;
                        m01_axis_tlast  <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_header_extractor.sv
// tb/tb_axis_header_extractor.sv - scoreboard bench for axis_header_extractor
module tb_axis_header_extractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_len_tvalid = 1'b0;
    logic        s_len_tready;
    logic [2:0]  s_len_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m00_axis_tvalid;
    logic        m00_axis_tready = 1'b0;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tkeep;
    logic        m01_axis_tvalid;
    logic        m01_axis_tready = 1'b0;
    logic [31:0] m01_axis_tdata;
    logic [3:0]  m01_axis_tkeep;
    logic        m01_axis_tlast;
`ifdef HDR_SHORT_CHECK_EN
    logic        err_short_pkt;
`endif

    always #5 clk = ~clk;

    axis_header_extractor #(.DATA_WD(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_len_tvalid    (s_len_tvalid),
        .s_len_tready    (s_len_tready),
        .s_len_tdata     (s_len_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tkeep  (m00_axis_tkeep),
        .m01_axis_tvalid (m01_axis_tvalid),
        .m01_axis_tready (m01_axis_tready),
        .m01_axis_tdata  (m01_axis_tdata),
        .m01_axis_tkeep  (m01_axis_tkeep),
        .m01_axis_tlast  (m01_axis_tlast)
`ifdef HDR_SHORT_CHECK_EN
        ,
        .err_short_pkt   (err_short_pkt)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t hdr_q[$];
    beat_t pay_q[$];
    int    tests = 0;
    int    fails = 0;
    int    rdy_mode = 0;
    logic  h00 = 1'b0;
    logic  h01 = 1'b0;
    beat_t held00;
    beat_t held01;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected expected none", name);
    endtask

    // Sink ready pattern: 0 always ready, 1 random 50%, 2 stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: begin m00_axis_tready = 1'b1; m01_axis_tready = 1'b1; end
            1: begin m00_axis_tready = 1'($urandom % 2); m01_axis_tready = 1'($urandom % 2); end
            default: begin m00_axis_tready = 1'b0; m01_axis_tready = 1'b0; end
        endcase
    end

    // Monitor: pops expected beats on every handshake and checks hold stability.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            h00 = 1'b0;
            h01 = 1'b0;
        end else begin
            if (h00 && m00_axis_tvalid)
                check("hdr_stable", {m00_axis_tdata, m00_axis_tkeep}, {held00.d, held00.k});
            if (h01 && m01_axis_tvalid)
                check("pay_stable", {m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast}, held01);
            h00 = m00_axis_tvalid && !m00_axis_tready;
            h01 = m01_axis_tvalid && !m01_axis_tready;
            held00 = '{d: m00_axis_tdata, k: m00_axis_tkeep, l: 1'b0};
            held01 = '{d: m01_axis_tdata, k: m01_axis_tkeep, l: m01_axis_tlast};
            if (m00_axis_tvalid && m00_axis_tready) begin
                if (hdr_q.size() == 0) fail_now("hdr_unexpected");
                else begin
                    e = hdr_q.pop_front();
                    check("hdr", {m00_axis_tdata, m00_axis_tkeep}, {e.d, e.k});
                end
            end
            if (m01_axis_tvalid && m01_axis_tready) begin
                if (pay_q.size() == 0) fail_now("pay_unexpected");
                else begin
                    e = pay_q.pop_front();
                    check("pay", {m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast}, e);
                end
            end
        end
    end

    task automatic send_len(input logic [2:0] h);
        int n = 0;
        s_len_tdata  = h;
        s_len_tvalid = 1'b1;
        @(negedge clk);
        while (!s_len_tready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) fail_now("len_timeout");
        @(posedge clk); #1;
        s_len_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) fail_now("beat_timeout");
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic exp_hdr(input logic [31:0] d, input logic [3:0] k);
        hdr_q.push_back('{d: d, k: k, l: 1'b0});
    endtask

    task automatic exp_pay(input logic [31:0] d, input logic [3:0] k, input logic l);
        pay_q.push_back('{d: d, k: k, l: l});
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((hdr_q.size() != 0 || pay_q.size() != 0 || m00_axis_tvalid || m01_axis_tvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_m00_valid", m00_axis_tvalid, 0);
        check("rst_m01_valid", {m01_axis_tvalid, m01_axis_tlast}, 0);
        check("rst_data", {m00_axis_tdata, m01_axis_tdata}, 0);
        check("rst_keep", {m00_axis_tkeep, m01_axis_tkeep}, 0);
        check("rst_readies", {s_len_tready, s_axis_tready}, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // H=2, three beats.
        exp_hdr(32'hAABB0000, 4'b1100);
        exp_pay(32'h11223344, 4'b1111, 1'b0);
        exp_pay(32'h55667788, 4'b1111, 1'b1);
        send_len(3'd2);
        send_beat(32'hAABB1122, 4'b1111, 1'b0);
        check("first_lat", {m00_axis_tvalid, m01_axis_tvalid}, 2'b10);
        send_beat(32'h33445566, 4'b1111, 1'b0);
        check("body_lat", m01_axis_tvalid, 1);
        send_beat(32'h77880000, 4'b1100, 1'b1);
        wait_drain();

        // H=1 with TAIL.
        exp_hdr(32'hAA000000, 4'b1000);
        exp_pay(32'h11223344, 4'b1111, 1'b0);
        exp_pay(32'h55667700, 4'b1110, 1'b1);
        send_len(3'd1);
        send_beat(32'hAA112233, 4'b1111, 1'b0);
        send_beat(32'h44556677, 4'b1111, 1'b1);
        check("tail_readies", {s_len_tready, s_axis_tready}, 2'b00);
        wait_drain();

        // H=4 passthrough, no TAIL.
        exp_hdr(32'hDEADBEEF, 4'b1111);
        exp_pay(32'h01020304, 4'b1111, 1'b0);
        exp_pay(32'h05060708, 4'b1111, 1'b0);
        exp_pay(32'h090A0B00, 4'b1110, 1'b1);
        send_len(3'd4);
        send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b0);
        send_beat(32'h090A0B00, 4'b1110, 1'b1);
        check("h4_no_tail", s_len_tready, 1);
        wait_drain();

        // H=3 single beat with residual.
        exp_hdr(32'hAABBCC00, 4'b1110);
        exp_pay(32'h11000000, 4'b1000, 1'b1);
        send_len(3'd3);
        send_beat(32'hAABBCC11, 4'b1111, 1'b1);
        check("single_lat", {m01_axis_tvalid, s_len_tready}, 2'b11);
        wait_drain();

        // H=3 short packet: header only.
        exp_hdr(32'hAABB0000, 4'b1100);
        send_len(3'd3);
        send_beat(32'hAABB0000, 4'b1100, 1'b1);
`ifdef HDR_SHORT_CHECK_EN
        check("err_pulse", err_short_pkt, 1);
`endif
        check("short_no_pay", m01_axis_tvalid, 0);
        wait_drain();

        // Length 0 treated as full width.
        exp_hdr(32'h12345678, 4'b1111);
        send_len(3'd0);
        send_beat(32'h12345678, 4'b1111, 1'b1);
        check("len0_no_pay", m01_axis_tvalid, 0);
        wait_drain();

        // Random backpressure on both outputs.
        rdy_mode = 1;
        exp_hdr(32'h01020000, 4'b1100);
        exp_pay(32'h03040506, 4'b1111, 1'b0);
        exp_pay(32'h0708090A, 4'b1111, 1'b1);
        send_len(3'd2);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b0);
        send_beat(32'h090A0000, 4'b1100, 1'b1);
        exp_hdr(32'hCA000000, 4'b1000);
        exp_pay(32'hFEBABE10, 4'b1111, 1'b1);
        send_len(3'd1);
        send_beat(32'hCAFEBABE, 4'b1111, 1'b0);
        send_beat(32'h10203040, 4'b1000, 1'b1);
        wait_drain();

        // Stall outputs, reset mid-BODY, then a fresh packet.
        rdy_mode = 2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send_len(3'd2);
        send_beat(32'h99887766, 4'b1111, 1'b0);
        send_beat(32'h55443322, 4'b1111, 1'b0);
        check("pre_rst_valids", {m00_axis_tvalid, m01_axis_tvalid}, 2'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_valids_async", {m00_axis_tvalid, m01_axis_tvalid, m01_axis_tlast}, 0);
        check("rst_readies_async", {s_len_tready, s_axis_tready}, 2'b10);
        rdy_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_hdr(32'hAABBCC00, 4'b1110);
        exp_pay(32'h11000000, 4'b1000, 1'b1);
        send_len(3'd3);
        send_beat(32'hAABBCC11, 4'b1111, 1'b1);
        wait_drain();

        check("queues_empty", hdr_q.size() + pay_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_header_extractor.md
# axis_header_extractor

Strips a per-packet header of 1..DATA_BYTE_WD bytes from the front of an AXI Stream packet. The header goes out on a dedicated header channel. The remaining payload is byte-realigned to the MSB and goes out as a separate AXI Stream. It sits on the receive side of a link whose transmit side prepends headers with the header inserter, and it is the exact inverse of that inserter. Byte order is MSB-first: byte 0 is tdata[DATA_WD-1 -: 8], and tkeep is contiguous and left-aligned (MSB side).

## Interface
- DATA_WD, 32, data width in bits; must be a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_len_tvalid / s_len_tready  in/out  1  header-length channel; one transfer per packet.
- s_len_tdata  in  $clog2(DATA_BYTE_WD+1)  header length H in bytes; legal range 1..DATA_BYTE_WD; 0 or >DATA_BYTE_WD is treated as DATA_BYTE_WD.
- s_axis_tvalid / s_axis_tready  in/out  1  input stream handshake.
- s_axis_tdata  in  DATA_WD  input data.
- s_axis_tkeep  in  DATA_BYTE_WD  input byte enables, left-aligned.
- s_axis_tlast  in  1  last input beat of the packet.
- m00_axis_tvalid / m00_axis_tready  out/in  1  header output handshake.
- m00_axis_tdata  out  DATA_WD  header bytes, left-aligned; unused bytes are 0.
- m00_axis_tkeep  out  DATA_BYTE_WD  header byte enables.
- m01_axis_tvalid / m01_axis_tready  out/in  1  payload output handshake.
- m01_axis_tdata  out  DATA_WD  realigned payload; unused bytes are 0.
- m01_axis_tkeep  out  DATA_BYTE_WD  payload byte enables, left-aligned.
- m01_axis_tlast  out  1  last payload beat.
- err_short_pkt  out  1  present only with HDR_SHORT_CHECK_EN (see Configuration).

## Operation
- Let H be the latched length, R = DATA_BYTE_WD-H the residual width, and k the popcount of the beat's tkeep.
- FSM states: IDLE, FIRST, BODY, TAIL.
- IDLE:
  - s_len_tready=1.
  - On a length handshake, latch H and go to FIRST.
- FIRST (header beat):
  - Accept the beat when the header output register is free and the payload register is free.
  - Header output = the top H bytes of the beat; its keep is the top min(k,H) bits.
  - Residual buffer = the low R bytes; residual count = k-H, clamped at 0.
  - With tlast:
    - If k>H, emit the residual as the payload beat, left-shifted by H bytes, with tlast. Go to IDLE.
    - If k<=H, emit no payload beat. Go to IDLE.
  - Without tlast, go to BODY.
- BODY (per accepted beat):
  - Output = {residual R bytes, top H bytes of the beat}.
  - New residual = low R bytes of the beat; residual count = k-H.
  - With tlast and k<=H: output keep covers R+k bytes, tlast=1, go to IDLE.
  - With tlast and k>H: output a full beat with tlast=0, go to TAIL.
- TAIL:
  - s_axis_tready=0.
  - Emit the residual left-aligned, keep = top (k-H) bits, tlast=1.
  - On the payload handshake, go to IDLE.
- H=DATA_BYTE_WD (no realignment):
  - The first beat is the header only.
  - Later beats pass through unchanged.
  - TAIL is never entered.
- s_len_tready=0 outside IDLE. Input beats arriving before their length transfer are stalled (s_axis_tready=0 in IDLE).
- Payload beats never carry tkeep=0.

## Timing
- Reset values:
  - All tvalid outputs 0; all tdata and tkeep outputs 0; m01_axis_tlast=0; err_short_pkt=0.
  - FSM in IDLE; s_len_tready=1; s_axis_tready=0.
- Both output channels are registered: output is valid the cycle after the accepting input edge.
- Payload latency:
  - The first payload beat appears 1 cycle after the second input beat is accepted, or after the first beat if that beat has tlast.
  - TAIL adds exactly one beat.
- Throughput: 1 beat per cycle sustained in BODY with no backpressure.
- Backpressure:
  - s_axis_tready = state ∈ {FIRST, BODY} AND (payload register empty OR m01 handshake this cycle) AND (state≠FIRST OR header register empty OR m00 handshake this cycle).
  - s_axis_tready never depends combinationally on s_axis_tvalid.
- Output stability: a held output (tvalid=1, tready=0) keeps tdata, tkeep and tlast stable until the handshake.
- Back-to-back packets: IDLE lasts exactly one cycle when s_len_tvalid is already high.
- Reset mid-packet: all state, buffers and output valids clear asynchronously; the partial packet is discarded.

## Configuration
- HDR_SHORT_CHECK_EN defined:
  - err_short_pkt pulses high for 1 cycle when a FIRST beat with tlast and k<H is accepted.
  - The header is still emitted with keep covering k bytes.
- HDR_SHORT_CHECK_EN undefined:
  - No err_short_pkt port and no check logic.
  - Header behaviour is identical.

## Test plan
All scenarios use DATA_WD=32.
- H=2; beats 0xAABB1122/1111, 0x33445566/1111, 0x77880000/1100 last -> header 0xAABB0000/1100; payload 0x11223344/1111, then 0x55667788/1111 last.
- H=1; beats 0xAA112233/1111, 0x44556677/1111 last -> header 0xAA000000/1000; payload 0x11223344/1111, then tail 0x55667700/1110 last; s_axis_tready=0 during TAIL.
- H=4; header 0xDEADBEEF, then 3 payload beats -> payload is bit-identical to input, last tlast preserved, no TAIL cycle.
- H=3; single beat 0xAABBCC11/1111 last -> header 0xAABBCC00/1110; payload 0x11000000/1000 last.
- H=3; single beat 0xAABB0000/1100 last -> header keep 1100, no payload beat, err_short_pkt pulse (macro defined).
- Random m00/m01 tready at 50%, then rst_n low mid-BODY -> no data loss or duplication; all valids 0 immediately; next packet correct.
